pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall/flush controls of the PC, F/D, D/E and E/M registers, and the EX-stage operand forwarding selects.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: RV32 opcode fields,
// forwarding select encodings and FSM state codes.
package pipe_pkg;

    // inst[6:2] opcode fields
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle. The pipeline (master) presents stage
// fields; the controller (slave) returns stall/flush/forward controls and its state.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs1_index;
    logic [4:0] id_rs2_index;
    logic [4:0] id_opcode;
    logic [4:0] ex_rs1_index;
    logic [4:0] ex_rs2_index;
    logic [4:0] ex_rd_index;
    logic [4:0] ex_opcode;
    logic       ex_wb_en;
    logic       ex_guess;
    logic       ex_taken;
    logic       ex_ecall;
    logic [4:0] mem_rd_index;
    logic       mem_wb_en;
    logic [4:0] wb_rd_index;
    logic       wb_wb_en;
    logic       dm_req;
    logic       dm_ready;

    logic       pc_stall;
    logic       fd_stall;
    logic       fd_flush;
    logic       de_flush;
    logic       de_stall;
    logic       em_stall;
    logic [1:0] fwd_rs1_sel;
    logic [1:0] fwd_rs2_sel;
    logic       halt;
    logic       mem_err;
    logic [1:0] state;

    // Data memory handshake: dm_req marks an access in MEM, dm_ready completes
    // it in the same cycle; req high with ready low freezes the whole pipeline.
    modport master (
        output id_rs1_index, id_rs2_index, id_opcode,
        output ex_rs1_index, ex_rs2_index, ex_rd_index, ex_opcode,
        output ex_wb_en, ex_guess, ex_taken, ex_ecall,
        output mem_rd_index, mem_wb_en, wb_rd_index, wb_wb_en,
        output dm_req, dm_ready,
        input  pc_stall, fd_stall, fd_flush, de_flush, de_stall, em_stall,
        input  fwd_rs1_sel, fwd_rs2_sel, halt, mem_err, state
    );

    modport slave (
        input  id_rs1_index, id_rs2_index, id_opcode,
        input  ex_rs1_index, ex_rs2_index, ex_rd_index, ex_opcode,
        input  ex_wb_en, ex_guess, ex_taken, ex_ecall,
        input  mem_rd_index, mem_wb_en, wb_rd_index, wb_wb_en,
        input  dm_req, dm_ready,
        output pc_stall, fd_stall, fd_flush, de_flush, de_stall, em_stall,
        output fwd_rs1_sel, fwd_rs2_sel, halt, mem_err, state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one source register; MEM result wins over WB,
// and x0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs_index,
    input  logic [4:0] mem_rd_index,
    input  logic       mem_wb_en,
    input  logic [4:0] wb_rd_index,
    input  logic       wb_wb_en,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_wb_en && (mem_rd_index != 5'd0) && (mem_rd_index == ex_rs_index))
            sel = FWD_MEM;
        else if (wb_wb_en && (wb_rd_index != 5'd0) && (wb_rd_index == ex_rs_index))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubbles,
// mispredict flushes, data-memory freezes, ecall drain-then-halt, and forwarding.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int CNT_MAX = (MEM_TIMEOUT > DRAIN_CYCLES) ? MEM_TIMEOUT : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mem_err_q, mem_err_nxt;

    logic mem_wait, mispredict, load_use, id_reads_rs1, id_reads_rs2, run_eval;
    logic pc_stall_c, fd_stall_c, fd_flush_c, de_flush_c, de_stall_c, em_stall_c;
    logic [1:0] fwd1_c, fwd2_c;

    assign mem_wait = hz.dm_req && !hz.dm_ready;

    assign mispredict = ((hz.ex_opcode == OP_BRANCH) && (hz.ex_guess != hz.ex_taken)) ||
                        (hz.ex_opcode == OP_JALR) ||
                        ((hz.ex_opcode == OP_JAL) && !hz.ex_guess);

    assign id_reads_rs1 = (hz.id_opcode != OP_LUI) && (hz.id_opcode != OP_AUIPC) &&
                          (hz.id_opcode != OP_JAL);
    assign id_reads_rs2 = (hz.id_opcode == OP_OP) || (hz.id_opcode == OP_STORE) ||
                          (hz.id_opcode == OP_BRANCH);

    assign load_use = (hz.ex_opcode == OP_LOAD) && hz.ex_wb_en && (hz.ex_rd_index != 5'd0) &&
                      ((id_reads_rs1 && (hz.ex_rd_index == hz.id_rs1_index)) ||
                       (id_reads_rs2 && (hz.ex_rd_index == hz.id_rs2_index)));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mem_err_nxt = mem_err_q;
        run_eval    = 1'b0;
        pc_stall_c  = 1'b0;
        fd_stall_c  = 1'b0;
        fd_flush_c  = 1'b0;
        de_flush_c  = 1'b0;
        de_stall_c  = 1'b0;
        em_stall_c  = 1'b0;

        case (state)
            ST_RUN: run_eval = 1'b1;
            ST_MEM_WAIT: begin
                // The release cycle is evaluated as an ordinary RUN cycle.
                if (hz.dm_ready) begin
                    run_eval = 1'b1;
                end else begin
                    {pc_stall_c, fd_stall_c, de_stall_c, em_stall_c} = 4'b1111;
                    if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                        state_nxt   = ST_HALT;
                        mem_err_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                pc_stall_c = 1'b1;
                fd_flush_c = 1'b1;
                de_flush_c = 1'b1;
                if (cnt == CW'(DRAIN_CYCLES - 1))
                    state_nxt = ST_HALT;
                else
                    cnt_nxt = cnt + CW'(1);
            end
            default: {pc_stall_c, fd_stall_c, de_stall_c, em_stall_c} = 4'b1111;
        endcase

        if (run_eval) begin
            state_nxt = ST_RUN;
            if (mem_wait) begin
                {pc_stall_c, fd_stall_c, de_stall_c, em_stall_c} = 4'b1111;
                state_nxt = ST_MEM_WAIT;
                cnt_nxt   = CW'(1);
            end else if (hz.ex_ecall) begin
                pc_stall_c = 1'b1;
                fd_flush_c = 1'b1;
                de_flush_c = 1'b1;
                state_nxt  = ST_DRAIN;
                cnt_nxt    = '0;
            end else if (mispredict) begin
                fd_flush_c = 1'b1;
                de_flush_c = 1'b1;
            end else if (load_use) begin
                pc_stall_c = 1'b1;
                fd_stall_c = 1'b1;
                de_flush_c = 1'b1;
            end
        end
    end

    // State moves on the falling edge, together with the pipeline registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_err_q <= mem_err_nxt;
        end
    end

    fwd_unit u_fwd_rs1 (
        .ex_rs_index  (hz.ex_rs1_index),
        .mem_rd_index (hz.mem_rd_index),
        .mem_wb_en    (hz.mem_wb_en),
        .wb_rd_index  (hz.wb_rd_index),
        .wb_wb_en     (hz.wb_wb_en),
        .sel          (fwd1_c)
    );

    fwd_unit u_fwd_rs2 (
        .ex_rs_index  (hz.ex_rs2_index),
        .mem_rd_index (hz.mem_rd_index),
        .mem_wb_en    (hz.mem_wb_en),
        .wb_rd_index  (hz.wb_rd_index),
        .wb_wb_en     (hz.wb_wb_en),
        .sel          (fwd2_c)
    );

    // Everything is forced low while reset is held.
    assign hz.pc_stall    = rst & pc_stall_c;
    assign hz.fd_stall    = rst & fd_stall_c;
    assign hz.fd_flush    = rst & fd_flush_c;
    assign hz.de_flush    = rst & de_flush_c;
    assign hz.de_stall    = rst & de_stall_c;
    assign hz.em_stall    = rst & em_stall_c;
    assign hz.fwd_rs1_sel = rst ? fwd1_c : FWD_RF;
    assign hz.fwd_rs2_sel = rst ? fwd2_c : FWD_RF;
    assign hz.halt        = rst & (state == ST_HALT);
    assign hz.mem_err     = rst & mem_err_q;
    assign hz.state       = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a mode-level reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int DRAIN   = 2;

  // Output vector: pc fd_st fd_fl de_fl de_st em_st f1[2] f2[2] halt err
  localparam logic [11:0] E_ZERO = 12'b0000_00_00_00_0_0;
  localparam logic [11:0] E_LU   = 12'b1101_00_00_00_0_0;
  localparam logic [11:0] E_MP   = 12'b0011_00_00_00_0_0;
  localparam logic [11:0] E_MW   = 12'b1100_11_00_00_0_0;
  localparam logic [11:0] E_EC   = 12'b1011_00_00_00_0_0;
  localparam logic [11:0] E_H    = 12'b1100_11_00_00_1_0;
  localparam logic [11:0] E_HE   = 12'b1100_11_00_00_1_1;
  localparam logic [11:0] E_F1M  = 12'b0000_00_01_00_0_0;
  localparam logic [11:0] E_F1W  = 12'b0000_00_10_00_0_0;
  localparam logic [11:0] E_F2W  = 12'b0000_00_00_10_0_0;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Mode: 0 running, 1 waiting on memory, 2 draining after ecall, 3 halted.
  int   m_mode        = 0;
  int   m_low_cycles  = 0;
  int   m_drained     = 0;
  logic m_err         = 1'b0;
  logic [11:0] exp_vec;
  logic [11:0] dut_vec;

  function automatic logic [1:0] fwd_of(logic [4:0] rs);
    if (hz.mem_wb_en && hz.mem_rd_index != 0 && hz.mem_rd_index == rs) return 2'b01;
    if (hz.wb_wb_en && hz.wb_rd_index != 0 && hz.wb_rd_index == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit is_mispredict();
    return (hz.ex_opcode == OP_BRANCH && hz.ex_guess != hz.ex_taken) ||
           hz.ex_opcode == OP_JALR || (hz.ex_opcode == OP_JAL && !hz.ex_guess);
  endfunction

  function automatic bit is_load_use();
    bit r1, r2;
    r1 = !(hz.id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    r2 = hz.id_opcode inside {OP_OP, OP_STORE, OP_BRANCH};
    return hz.ex_opcode == OP_LOAD && hz.ex_wb_en && hz.ex_rd_index != 0 &&
           ((r1 && hz.ex_rd_index == hz.id_rs1_index) || (r2 && hz.ex_rd_index == hz.id_rs2_index));
  endfunction

  function automatic bit runs_normally();
    return m_mode == 0 || (m_mode == 1 && hz.dm_ready);
  endfunction

  always_comb begin
    exp_vec = E_ZERO;
    if (rst) begin
      exp_vec[5:4] = fwd_of(hz.ex_rs1_index);
      exp_vec[3:2] = fwd_of(hz.ex_rs2_index);
      exp_vec[0]   = m_err;
      if (m_mode == 3) begin
        exp_vec[11:10] = 2'b11; exp_vec[7:6] = 2'b11; exp_vec[1] = 1'b1;
      end else if (m_mode == 2) begin
        exp_vec[11] = 1'b1; exp_vec[9:8] = 2'b11;
      end else if (m_mode == 1 && !hz.dm_ready) begin
        exp_vec[11:10] = 2'b11; exp_vec[7:6] = 2'b11;
      end else if (hz.dm_req && !hz.dm_ready) begin
        exp_vec[11:10] = 2'b11; exp_vec[7:6] = 2'b11;
      end else if (hz.ex_ecall) begin
        exp_vec[11] = 1'b1; exp_vec[9:8] = 2'b11;
      end else if (is_mispredict()) begin
        exp_vec[9:8] = 2'b11;
      end else if (is_load_use()) begin
        exp_vec[11:10] = 2'b11; exp_vec[8] = 1'b1;
      end
    end
  end

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_low_cycles = 0; m_drained = 0; m_err = 1'b0;
    end else if (m_mode == 2) begin
      m_drained = m_drained + 1;
      if (m_drained == DRAIN) m_mode = 3;
    end else if (m_mode == 1 && !hz.dm_ready) begin
      m_low_cycles = m_low_cycles + 1;
      if (m_low_cycles == TIMEOUT) begin m_mode = 3; m_err = 1'b1; end
    end else if (runs_normally()) begin
      if (hz.dm_req && !hz.dm_ready) begin
        m_mode = 1; m_low_cycles = 1;
      end else if (hz.ex_ecall) begin
        m_mode = 2; m_drained = 0;
      end else begin
        m_mode = 0;
      end
    end
  end

  assign dut_vec = {hz.pc_stall, hz.fd_stall, hz.fd_flush, hz.de_flush, hz.de_stall,
                    hz.em_stall, hz.fwd_rs1_sel, hz.fwd_rs2_sel, hz.halt, hz.mem_err};

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    #2;
    n_checks++;
    if (dut_vec !== exp_vec) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t got %b expected %b", $time, dut_vec, exp_vec);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
  endtask

  task automatic set_idle();
    hz.id_rs1_index = 0; hz.id_rs2_index = 0; hz.id_opcode = OP_OPIMM;
    hz.ex_rs1_index = 0; hz.ex_rs2_index = 0; hz.ex_rd_index = 0;
    hz.ex_opcode = OP_OPIMM; hz.ex_wb_en = 0; hz.ex_guess = 0; hz.ex_taken = 0;
    hz.ex_ecall = 0; hz.mem_rd_index = 0; hz.mem_wb_en = 0;
    hz.wb_rd_index = 0; hz.wb_wb_en = 0; hz.dm_req = 0; hz.dm_ready = 1;
  endtask

  task automatic load_pattern(input logic [4:0] id_op);
    set_idle();
    hz.ex_opcode = OP_LOAD; hz.ex_rd_index = 5; hz.ex_wb_en = 1;
    hz.id_opcode = id_op; hz.id_rs2_index = 5;
  endtask

  task automatic pin(input logic [11:0] exp, input string name);
    #2;
    n_checks++;
    if (dut_vec !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, dut_vec, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    set_idle();
    hz.dm_req = 1; hz.dm_ready = 0; hz.ex_ecall = 1;
    hz.ex_rs1_index = 7; hz.mem_rd_index = 7; hz.mem_wb_en = 1;
    next_cycle(); pin(E_ZERO, "reset_hold");
    next_cycle(); pin(E_ZERO, "reset_hold2");
    next_cycle(); rst = 1'b1; set_idle(); pin(E_ZERO, "run_idle");

    // load-use and its non-hazards
    next_cycle(); load_pattern(OP_OP); pin(E_LU, "load_use_op_rs2");
    next_cycle(); set_idle(); pin(E_ZERO, "one_bubble_only");
    next_cycle(); load_pattern(OP_LUI); hz.id_rs1_index = 5; pin(E_ZERO, "load_use_lui");
    next_cycle(); load_pattern(OP_OPIMM); hz.id_rs1_index = 3; pin(E_ZERO, "opimm_no_rs2");
    next_cycle(); load_pattern(OP_STORE); hz.id_rs2_index = 0; hz.id_rs1_index = 5;
    pin(E_LU, "load_use_store_rs1");
    next_cycle(); load_pattern(OP_OP); hz.ex_rd_index = 0; hz.id_rs2_index = 0;
    pin(E_ZERO, "load_x0");

    // mispredicts take priority over the load-use fields
    next_cycle(); load_pattern(OP_OP); hz.ex_opcode = OP_BRANCH; hz.ex_guess = 1; hz.ex_taken = 0;
    pin(E_MP, "mispredict_branch");
    next_cycle(); set_idle(); hz.ex_opcode = OP_BRANCH; hz.ex_guess = 1; hz.ex_taken = 1;
    pin(E_ZERO, "branch_correct");
    next_cycle(); set_idle(); hz.ex_opcode = OP_JALR; hz.ex_guess = 1; pin(E_MP, "jalr_flush");
    next_cycle(); set_idle(); hz.ex_opcode = OP_JAL; hz.ex_guess = 1; pin(E_ZERO, "jal_predicted");
    next_cycle(); set_idle(); hz.ex_opcode = OP_JAL; hz.ex_guess = 0; pin(E_MP, "jal_unpredicted");

    // forwarding
    next_cycle(); set_idle(); hz.ex_rs1_index = 7; hz.ex_rs2_index = 9;
    hz.mem_rd_index = 7; hz.wb_rd_index = 7; hz.mem_wb_en = 1; hz.wb_wb_en = 1;
    pin(E_F1M, "fwd_mem_priority");
    next_cycle(); hz.mem_wb_en = 0; pin(E_F1W, "fwd_wb");
    next_cycle(); hz.mem_wb_en = 1; hz.ex_rs1_index = 0; hz.mem_rd_index = 0; hz.wb_rd_index = 0;
    pin(E_ZERO, "fwd_x0");
    next_cycle(); set_idle(); hz.ex_rs2_index = 4; hz.mem_rd_index = 3; hz.mem_wb_en = 1;
    hz.wb_rd_index = 4; hz.wb_wb_en = 1; pin(E_F2W, "fwd_rs2_wb");

    // memory wait of three cycles, released on ready
    next_cycle(); set_idle(); hz.dm_req = 1; hz.dm_ready = 0; pin(E_MW, "mem_wait_1");
    next_cycle(); pin(E_MW, "mem_wait_2");
    next_cycle(); pin(E_MW, "mem_wait_3");
    next_cycle(); hz.dm_ready = 1; pin(E_ZERO, "mem_release");
    next_cycle(); set_idle(); pin(E_ZERO, "after_release");

    // ecall drain then halt
    next_cycle(); set_idle(); hz.ex_ecall = 1; pin(E_EC, "ecall");
    next_cycle(); set_idle(); pin(E_EC, "drain_1");
    next_cycle(); pin(E_EC, "drain_2");
    next_cycle(); pin(E_H, "halt_1");
    next_cycle(); hz.ex_ecall = 1; pin(E_H, "halt_sticky");
    next_cycle(); rst = 1'b0; pin(E_ZERO, "reset_from_halt");
    next_cycle(); rst = 1'b1; set_idle(); pin(E_ZERO, "run_after_halt");

    // reset in the middle of a drain
    next_cycle(); hz.ex_ecall = 1; pin(E_EC, "ecall_again");
    next_cycle(); set_idle(); pin(E_EC, "drain_again");
    next_cycle(); rst = 1'b0; pin(E_ZERO, "reset_mid_drain");
    next_cycle(); rst = 1'b1; pin(E_ZERO, "run_after_drain_reset");
    next_cycle(); pin(E_ZERO, "no_halt_after_reset");
    next_cycle(); pin(E_ZERO, "still_running");

    // memory timeout: sixteen low cycles
    next_cycle(); set_idle(); hz.dm_req = 1; hz.dm_ready = 0; pin(E_MW, "timeout_first");
    for (int i = 2; i <= TIMEOUT; i++) next_cycle();
    pin(E_MW, "timeout_last_wait");
    next_cycle(); pin(E_HE, "timeout_halt");
    next_cycle(); set_idle(); pin(E_HE, "mem_err_sticky");
    next_cycle(); rst = 1'b0; pin(E_ZERO, "reset_clears_err");
    next_cycle(); rst = 1'b1; pin(E_ZERO, "run_after_err");

    next_cycle();
    #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
